// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard-controller pipeline signals; master drives pipeline state, slave is the controller
interface pipe_hazard_ctrl_if #(parameter int REG_W = 4);
  logic [REG_W-1:0] rs1_id, rs2_id, rd_ex;
  logic mem_read_ex, branch_taken_ex, mul_start_id, mul_done;
  logic stall_if, stall_id, flush_id, flush_ex, busy, mul_err;
  logic [15:0] stall_cnt;
  modport master(
    output rs1_id, rs2_id, rd_ex, mem_read_ex, branch_taken_ex, mul_start_id, mul_done,
    input stall_if, stall_id, flush_id, flush_ex, busy, mul_err, stall_cnt
  );
  modport slave(
    input rs1_id, rs2_id, rd_ex, mem_read_ex, branch_taken_ex, mul_start_id, mul_done,
    output stall_if, stall_id, flush_id, flush_ex, busy, mul_err, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use / branch / modmul stall+flush control; PIPE_HAZARD_CTRL_TIMEOUT_EN adds a modmul watchdog
module pipe_hazard_ctrl #(
  parameter int REG_W       = 4,
  parameter int LU_CYCLES   = 1,
  parameter int MUL_TIMEOUT = 256
) (
  input logic clock,
  input logic reset,
  pipe_hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, LU_STALL, MUL_WAIT} state_t;
  localparam logic [3:0] LU_LAST = 4'(LU_CYCLES - 1);
  if (LU_CYCLES < 1 || LU_CYCLES > 15 || MUL_TIMEOUT < 2 || MUL_TIMEOUT > 65535) begin : g_bad_param
    $error("pipe_hazard_ctrl: LU_CYCLES or MUL_TIMEOUT out of range");
  end
  state_t state_q, state_d;
  logic [3:0] lu_cnt_q, lu_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic hazard, stall, flush_id, flush_ex;
`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(MUL_TIMEOUT - 1);
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic mul_err_q, mul_err_d;
`endif
  // next state and combinational stall/flush; reset overrides everything last
  always_comb begin
    hazard = bus.mem_read_ex && bus.rd_ex != REG_W'(0) &&
             (bus.rd_ex == bus.rs1_id || bus.rd_ex == bus.rs2_id);
    state_d = state_q;
    lu_cnt_d = lu_cnt_q;
    stall = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
    wd_cnt_d = wd_cnt_q;
    mul_err_d = 1'b0;
`endif
    case (state_q)
      RUN: begin
        if (bus.branch_taken_ex) begin
          flush_id = 1'b1;
          flush_ex = 1'b1;
        end else if (hazard) begin
          stall = 1'b1;
          flush_ex = 1'b1;
          if (LU_CYCLES > 1) begin
            state_d = LU_STALL;
            lu_cnt_d = 4'd1;
          end
        end else if (bus.mul_start_id) begin
          stall = 1'b1;
          state_d = MUL_WAIT;
`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
          wd_cnt_d = '0;
`endif
        end
      end
      LU_STALL: begin
        stall = 1'b1;
        flush_ex = 1'b1;
        lu_cnt_d = lu_cnt_q + 4'd1;
        if (lu_cnt_q == LU_LAST) begin
          state_d = RUN;
          lu_cnt_d = '0;
        end
      end
      MUL_WAIT: begin
        if (bus.mul_done) begin
          state_d = RUN;
`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
        end else if (wd_cnt_q == WD_LAST) begin
          state_d = RUN;
          mul_err_d = 1'b1;
`endif
        end else begin
          stall = 1'b1;
          flush_ex = 1'b1;
`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
          wd_cnt_d = wd_cnt_q + 16'd1;
`endif
        end
      end
      default: state_d = RUN;
    endcase
    if (reset) begin
      state_d = RUN;
      lu_cnt_d = '0;
      stall = 1'b0;
      flush_id = 1'b0;
      flush_ex = 1'b0;
`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
      wd_cnt_d = '0;
      mul_err_d = 1'b0;
`endif
    end
    stall_cnt_d = reset ? 16'd0 : (stall && ~&stall_cnt_q) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end
  // state and counter registers; reset is folded into the _d terms
  always_ff @(posedge clock) begin
    state_q <= state_d;
    lu_cnt_q <= lu_cnt_d;
    stall_cnt_q <= stall_cnt_d;
`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
    wd_cnt_q <= wd_cnt_d;
    mul_err_q <= mul_err_d;
`endif
  end
  assign bus.stall_if = stall;
  assign bus.stall_id = stall;
  assign bus.flush_id = flush_id;
  assign bus.flush_ex = flush_ex;
  assign bus.busy = state_q != RUN && !reset;
  assign bus.stall_cnt = stall_cnt_q;
`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
  assign bus.mul_err = mul_err_q;
`else
  assign bus.mul_err = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors into a scoreboard, checked by a per-cycle monitor
module tb_pipe_hazard_ctrl;
  logic clk, rst_a, rst_b;
  int checks, failures;
  typedef struct {logic [5:0] e; logic [15:0] c; string n;} exp_t;
  exp_t qa[$], qb[$];
  int base;
  pipe_hazard_ctrl_if #(.REG_W(4)) ia();
  pipe_hazard_ctrl_if #(.REG_W(4)) ib();
  pipe_hazard_ctrl #(.REG_W(4), .LU_CYCLES(1), .MUL_TIMEOUT(8)) dut_a (.clock(clk), .reset(rst_a), .bus(ia));
  pipe_hazard_ctrl #(.REG_W(4), .LU_CYCLES(3), .MUL_TIMEOUT(256)) dut_b (.clock(clk), .reset(rst_b), .bus(ib));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // expected bits: {stall_if, stall_id, flush_id, flush_ex, busy, mul_err}
  task automatic cyc(input bit b, input logic r, br, mr, ms, md, input logic [3:0] rd,
                     input logic [5:0] e, input logic [15:0] c, input string n);
    exp_t x;
    @(posedge clk);
    #1;
    if (!b) begin
      rst_a = r; ia.branch_taken_ex = br; ia.mem_read_ex = mr;
      ia.mul_start_id = ms; ia.mul_done = md; ia.rd_ex = rd;
    end else begin
      rst_b = r; ib.branch_taken_ex = br; ib.mem_read_ex = mr;
      ib.mul_start_id = ms; ib.mul_done = md; ib.rd_ex = rd;
    end
    x.e = e; x.c = c; x.n = n;
    if (!b) qa.push_back(x); else qb.push_back(x);
  endtask
  // monitor: outputs are valid every cycle, compare whatever is queued at the falling edge
  always @(negedge clk) begin
    exp_t x;
    logic [5:0] o;
    if (qa.size() > 0) begin
      x = qa.pop_front();
      o = {ia.stall_if, ia.stall_id, ia.flush_id, ia.flush_ex, ia.busy, ia.mul_err};
      checks++;
      if (o !== x.e || ia.stall_cnt !== x.c) begin
        failures++;
        $display("FAIL a:%s outs=%b cnt=%0d want outs=%b cnt=%0d", x.n, o, ia.stall_cnt, x.e, x.c);
      end
    end
    if (qb.size() > 0) begin
      x = qb.pop_front();
      o = {ib.stall_if, ib.stall_id, ib.flush_id, ib.flush_ex, ib.busy, ib.mul_err};
      checks++;
      if (o !== x.e || ib.stall_cnt !== x.c) begin
        failures++;
        $display("FAIL b:%s outs=%b cnt=%0d want outs=%b cnt=%0d", x.n, o, ib.stall_cnt, x.e, x.c);
      end
    end
  end
  initial begin
    checks = 0; failures = 0;
    rst_a = 1'b1; rst_b = 1'b1;
    ia.rs1_id = 4'd1; ia.rs2_id = 4'd3; ib.rs1_id = 4'd1; ib.rs2_id = 4'd3;
    ia.rd_ex = '0; ia.mem_read_ex = 0; ia.branch_taken_ex = 0; ia.mul_start_id = 0; ia.mul_done = 0;
    ib.rd_ex = '0; ib.mem_read_ex = 0; ib.branch_taken_ex = 0; ib.mul_start_id = 0; ib.mul_done = 0;
    repeat (2) @(posedge clk);
    // DUT A: LU_CYCLES=1, MUL_TIMEOUT=8
    cyc(0, 1, 0, 1, 0, 0, 4'd3, 6'b000000, 0, "reset_masks_hazard");
    cyc(0, 0, 0, 0, 0, 0, 4'd0, 6'b000000, 0, "idle");
    cyc(0, 0, 0, 1, 0, 0, 4'd3, 6'b110100, 0, "load_use_rs2");
    cyc(0, 0, 0, 0, 0, 0, 4'd0, 6'b000000, 1, "after_load_use");
    cyc(0, 0, 0, 1, 0, 0, 4'd0, 6'b000000, 1, "rd_zero");
    cyc(0, 0, 0, 0, 0, 0, 4'd3, 6'b000000, 1, "not_load");
    cyc(0, 0, 0, 1, 0, 0, 4'd1, 6'b110100, 1, "load_use_rs1");
    cyc(0, 0, 0, 1, 0, 0, 4'd5, 6'b000000, 2, "no_match");
    cyc(0, 0, 1, 1, 0, 0, 4'd3, 6'b001100, 2, "branch_over_hazard");
    cyc(0, 0, 1, 0, 1, 0, 4'd0, 6'b001100, 2, "branch_over_mul");
    cyc(0, 0, 0, 1, 1, 0, 4'd3, 6'b110100, 2, "hazard_over_mul");
    cyc(0, 0, 0, 0, 0, 1, 4'd0, 6'b000000, 3, "done_ignored_in_run");
    cyc(0, 0, 0, 0, 1, 0, 4'd0, 6'b110000, 3, "mul_start_a");
    for (int j = 0; j < 7; j++)
      cyc(0, 0, j == 1, 0, 0, 0, 4'd0, 6'b110110, 16'(4 + j), "mul_wait_a");
`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
    cyc(0, 0, 0, 0, 0, 0, 4'd0, 6'b000010, 11, "watchdog_fire");
    cyc(0, 0, 0, 0, 0, 0, 4'd0, 6'b000001, 11, "mul_err_pulse");
    cyc(0, 0, 0, 0, 0, 0, 4'd0, 6'b000000, 11, "after_mul_err");
    base = 11;
`else
    for (int j = 7; j < 12; j++)
      cyc(0, 0, 0, 0, 0, 0, 4'd0, 6'b110110, 16'(4 + j), "mul_hold_no_watchdog");
    cyc(0, 0, 0, 0, 0, 1, 4'd0, 6'b000010, 16, "mul_done_a");
    cyc(0, 0, 0, 0, 0, 0, 4'd0, 6'b000000, 16, "after_done_a");
    base = 16;
`endif
    cyc(0, 0, 0, 0, 1, 0, 4'd0, 6'b110000, 16'(base), "mul_start_a2");
    cyc(0, 0, 0, 0, 0, 0, 4'd0, 6'b110110, 16'(base + 1), "mul_wait_a2_0");
    cyc(0, 0, 0, 0, 0, 0, 4'd0, 6'b110110, 16'(base + 2), "mul_wait_a2_1");
    cyc(0, 1, 0, 0, 0, 0, 4'd0, 6'b000000, 16'(base + 3), "reset_in_mul_wait");
    cyc(0, 0, 0, 0, 0, 0, 4'd0, 6'b000000, 0, "post_reset_a");
    cyc(0, 0, 0, 0, 0, 0, 4'd0, 6'b000000, 0, "no_residual_a");
    // DUT B: LU_CYCLES=3
    cyc(1, 1, 0, 0, 0, 0, 4'd0, 6'b000000, 0, "reset_b");
    cyc(1, 0, 0, 0, 0, 0, 4'd0, 6'b000000, 0, "idle_b");
    cyc(1, 0, 0, 1, 0, 0, 4'd3, 6'b110100, 0, "lu_enter");
    cyc(1, 0, 0, 0, 0, 0, 4'd0, 6'b110110, 1, "lu_stall_1");
    cyc(1, 0, 1, 0, 0, 0, 4'd0, 6'b110110, 2, "lu_stall_2_branch_ignored");
    cyc(1, 0, 0, 0, 0, 0, 4'd0, 6'b000000, 3, "lu_done");
    cyc(1, 0, 0, 0, 1, 0, 4'd0, 6'b110000, 3, "mul_start_b");
    for (int j = 0; j < 9; j++)
      cyc(1, 0, 0, j == 3, 0, 0, j == 3 ? 4'd3 : 4'd0, 6'b110110, 16'(4 + j), "mul_wait_b");
    cyc(1, 0, 0, 0, 0, 1, 4'd0, 6'b000010, 13, "mul_done_b");
    cyc(1, 0, 0, 0, 0, 0, 4'd0, 6'b000000, 13, "after_done_b");
    cyc(1, 0, 0, 1, 0, 0, 4'd3, 6'b110100, 13, "lu_enter_2");
    cyc(1, 1, 0, 0, 0, 0, 4'd0, 6'b000000, 14, "reset_in_lu_stall");
    cyc(1, 0, 0, 0, 0, 0, 4'd0, 6'b000000, 0, "post_reset_b");
    cyc(1, 0, 0, 0, 0, 0, 4'd0, 6'b000000, 0, "no_residual_b");
    repeat (2) @(posedge clk);
    checks++;
    if (qa.size() + qb.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d want 0", qa.size() + qb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
